// File: rtl/wishbone_master_pipelined.sv
// Host command words to Wishbone B4 pipelined transactions: set-address, single-beat write,
// multi-beat read bursts with outstanding-beat tracking, bus timeout and host abort.
module wishbone_master_pipelined #(
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 10,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_cmd_stb,
  input  logic [DW+1:0]   i_cmd_word,
  output logic            o_cmd_busy,
  output logic            o_rsp_stb,
  output logic [DW+1:0]   o_rsp_word,
  input  logic            i_wb_err,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic [DW-1:0]   i_wb_data,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic [AW-1:0]   o_wb_addr,
  output logic            o_wb_we,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel
);

  localparam int unsigned BW = $clog2(MAX_BURST);
  localparam int unsigned CW = BW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [AW-1:0] AddrOne = AW'(1);
  localparam logic [CW-1:0] CntOne  = CW'(1);
  localparam logic [TW-1:0] TmoOne  = TW'(1);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);

  localparam logic [1:0] OpRead    = 2'b00;
  localparam logic [1:0] OpWrite   = 2'b01;
  localparam logic [1:0] OpSetAddr = 2'b10;
  localparam logic [1:0] OpAbort   = 2'b11;

  typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            inc_q, inc_d;
  logic            cyc_q, cyc_d;
  logic            stb_q, stb_d;
  logic            we_q, we_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [CW-1:0]   n_q, n_d;
  logic [CW-1:0]   issued_q, issued_d;
  logic [CW-1:0]   acked_q, acked_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [AW-1:0]   used_q, used_d;
  logic            rsp_stb_q, rsp_stb_d;
  logic [DW+1:0]   rsp_word_q, rsp_word_d;

  logic [1:0]      op;
  logic [DW-1:0]   payload;
  logic            stb_acc;
  logic [CW-1:0]   issued_nx;
  logic [CW-1:0]   acked_nx;
  logic            ack_ok;
  logic            abort_req;
  logic            tmo_hit;
  logic            done;

  assign op        = i_cmd_word[DW+1:DW];
  assign payload   = i_cmd_word[DW-1:0];
  assign stb_acc   = stb_q & ~i_wb_stall;
  assign issued_nx = issued_q + {{(CW-1){1'b0}}, stb_acc};
  assign acked_nx  = acked_q + CntOne;
  // A same-cycle ack for the strobe being accepted counts; acks beyond that are stray.
  assign ack_ok    = cyc_q & i_wb_ack & (acked_q != issued_nx);
  assign abort_req = i_cmd_stb & (op == OpAbort) & (state_q != StIdle);
  assign tmo_hit   = cyc_q & ~ack_ok & (tmo_q == TmoLast);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    inc_d      = inc_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    n_d        = n_q;
    issued_d   = issued_q;
    acked_d    = acked_q;
    tmo_d      = tmo_q;
    used_d     = used_q;
    rsp_stb_d  = 1'b0;
    rsp_word_d = rsp_word_q;
    done       = 1'b0;

    if (state_q == StIdle) begin
      if (i_cmd_stb) begin
        case (op)
          OpSetAddr: begin
            addr_d     = payload[AW-1:0];
            inc_d      = payload[DW-2];
            rsp_stb_d  = 1'b1;
            rsp_word_d = {2'b00, {(DW-AW){1'b0}}, payload[AW-1:0]};
          end
          OpWrite, OpRead: begin
            state_d  = (op == OpWrite) ? StWrite : StRead;
            cyc_d    = 1'b1;
            stb_d    = 1'b1;
            we_d     = (op == OpWrite);
            wdata_d  = (op == OpWrite) ? payload : wdata_q;
            n_d      = (op == OpWrite) ? CntOne : ({1'b0, payload[BW-1:0]} + CntOne);
            issued_d = '0;
            acked_d  = '0;
            tmo_d    = '0;
            used_d   = addr_q;
          end
          default: ;
        endcase
      end
    end else begin
      if (stb_acc) begin
        issued_d = issued_nx;
        if (issued_nx == n_q) stb_d = 1'b0;
        if (inc_q) addr_d = addr_q + AddrOne;
      end

      tmo_d = ack_ok ? '0 : tmo_q + TmoOne;

      if (ack_ok) begin
        acked_d    = acked_nx;
        rsp_stb_d  = 1'b1;
        rsp_word_d = (state_q == StWrite) ? {2'b01, {(DW-AW){1'b0}}, used_q}
                                          : {2'b10, i_wb_data};
        if (acked_nx == n_q) done = 1'b1;
      end

      // Later assignments win: abort over error over timeout over a plain ack.
      if (tmo_hit) begin
        done       = 1'b1;
        rsp_stb_d  = 1'b1;
        rsp_word_d = {2'b11, DW'(1)};
      end
      if (i_wb_err && cyc_q) begin
        done       = 1'b1;
        rsp_stb_d  = 1'b1;
        rsp_word_d = {2'b11, DW'(0)};
      end
      if (abort_req) begin
        done       = 1'b1;
        rsp_stb_d  = 1'b1;
        rsp_word_d = {2'b11, DW'(2)};
      end

      if (done) begin
        state_d = StIdle;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      inc_q      <= 1'b0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      n_q        <= '0;
      issued_q   <= '0;
      acked_q    <= '0;
      tmo_q      <= '0;
      used_q     <= '0;
      rsp_stb_q  <= 1'b0;
      rsp_word_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      inc_q      <= inc_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      n_q        <= n_d;
      issued_q   <= issued_d;
      acked_q    <= acked_d;
      tmo_q      <= tmo_d;
      used_q     <= used_d;
      rsp_stb_q  <= rsp_stb_d;
      rsp_word_q <= rsp_word_d;
    end
  end

  assign o_cmd_busy = (state_q != StIdle);
  assign o_rsp_stb  = rsp_stb_q;
  assign o_rsp_word = rsp_word_q;
  assign o_wb_cyc   = cyc_q;
  assign o_wb_stb   = stb_q;
  assign o_wb_addr  = addr_q;
  assign o_wb_we    = we_q;
  assign o_wb_data  = wdata_q;
  assign o_wb_sel   = {(DW/8){cyc_q}};

endmodule

// File: tb/tb_wishbone_master_pipelined.sv
// Randomized bench for wishbone_master_pipelined: a reference model queues expected responses
// and strobes; a monitor compares them against what the DUT presents.
module tb_wishbone_master_pipelined;

  localparam int DW      = 32;
  localparam int AW      = 10;
  localparam int BW      = 4;
  localparam int TIMEOUT = 255;

  logic            clk = 1'b0;
  logic            i_reset;
  logic            i_cmd_stb;
  logic [DW+1:0]   i_cmd_word;
  logic            o_cmd_busy;
  logic            o_rsp_stb;
  logic [DW+1:0]   o_rsp_word;
  logic            i_wb_err;
  logic            i_wb_stall;
  logic            i_wb_ack;
  logic [DW-1:0]   i_wb_data;
  logic            o_wb_cyc;
  logic            o_wb_stb;
  logic [AW-1:0]   o_wb_addr;
  logic            o_wb_we;
  logic [DW-1:0]   o_wb_data;
  logic [DW/8-1:0] o_wb_sel;

  wishbone_master_pipelined #(
    .DW(DW), .AW(AW), .MAX_BURST(16), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_cmd_stb  (i_cmd_stb),
    .i_cmd_word (i_cmd_word),
    .o_cmd_busy (o_cmd_busy),
    .o_rsp_stb  (o_rsp_stb),
    .o_rsp_word (o_rsp_word),
    .i_wb_err   (i_wb_err),
    .i_wb_stall (i_wb_stall),
    .i_wb_ack   (i_wb_ack),
    .i_wb_data  (i_wb_data),
    .o_wb_cyc   (o_wb_cyc),
    .o_wb_stb   (o_wb_stb),
    .o_wb_addr  (o_wb_addr),
    .o_wb_we    (o_wb_we),
    .o_wb_data  (o_wb_data),
    .o_wb_sel   (o_wb_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } stb_t;

  logic [DW+1:0] exp_rsp[$];
  stb_t          exp_stb[$];
  int            n_chk  = 0;
  int            n_pass = 0;

  // Reference model of the host-visible address register
  logic [AW-1:0] m_addr = '0;
  bit            m_inc  = 1'b0;

  function automatic logic [DW-1:0] zx(input logic [AW-1:0] a);
    return {{(DW-AW){1'b0}}, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: sampled mid-cycle, away from the active edge
  bit            prev_stall = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;
  logic          prev_we;

  always @(negedge clk) begin
    if (i_reset) begin
      prev_stall = 1'b0;
    end else begin
      if (o_rsp_stb) begin
        if (exp_rsp.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_rsp: actual=%0h required=none", o_rsp_word);
        end else begin
          chk("rsp_word", 64'(o_rsp_word), 64'(exp_rsp.pop_front()));
        end
      end
      if (prev_stall && o_wb_cyc)
        chk("stall_hold", {o_wb_stb, o_wb_we, o_wb_addr, o_wb_data},
            {1'b1, prev_we, prev_addr, prev_data});
      if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
        if (exp_stb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_stb: actual=%0h required=none", o_wb_addr);
        end else begin
          stb_t s;
          s = exp_stb.pop_front();
          chk("stb_addr_we", {o_wb_we, o_wb_addr}, {s.we, s.addr});
          if (s.we) chk("stb_wdata", 64'(o_wb_data), 64'(s.data));
        end
      end
      prev_stall = o_wb_cyc && o_wb_stb && i_wb_stall;
      prev_addr  = o_wb_addr;
      prev_data  = o_wb_data;
      prev_we    = o_wb_we;
    end
  end

  task automatic send(input logic [1:0] op, input logic [DW-1:0] p);
    i_cmd_stb  = 1'b1;
    i_cmd_word = {op, p};
    tick();
    i_cmd_stb  = 1'b0;
    i_cmd_word = '0;
  endtask

  task automatic set_addr(input logic [AW-1:0] a, input bit inc);
    logic [DW-1:0] p;
    p         = $urandom;
    p[AW-1:0] = a;
    p[DW-2]   = inc;
    m_addr    = a;
    m_inc     = inc;
    exp_rsp.push_back({2'b00, zx(a)});
    send(2'b10, p);
    chk("setaddr_not_busy", {o_cmd_busy, o_wb_cyc}, 2'b00);
  endtask

  task automatic wr(input logic [DW-1:0] d, output logic [AW-1:0] used);
    stb_t s;
    s.we = 1'b1; s.addr = m_addr; s.data = d;
    exp_stb.push_back(s);
    used = m_addr;
    if (m_inc) m_addr = m_addr + AW'(1);
    send(2'b01, d);
    chk("cmd_to_bus_wr", {o_wb_cyc, o_wb_stb, o_cmd_busy}, 3'b111);
  endtask

  task automatic rd(input int n);
    logic [DW-1:0] p;
    stb_t s;
    p         = $urandom;
    p[BW-1:0] = BW'(n - 1);
    for (int i = 0; i < n; i++) begin
      s.we = 1'b0; s.data = '0;
      s.addr = m_inc ? m_addr + AW'(i) : m_addr;
      exp_stb.push_back(s);
    end
    if (m_inc) m_addr = m_addr + AW'(n);
    send(2'b00, p);
    chk("cmd_to_bus_rd", {o_wb_cyc, o_wb_stb, o_cmd_busy}, 3'b111);
  endtask

  // Slave model; runs until cyc drops. err_beat/abort_beat: ack index at which to fail (-1 = never).
  task automatic serve(input int stall_pct, input int ack_pct, input bit comb,
                       input int err_beat, input int abort_beat, input bit acks_on,
                       input bit is_wr, input logic [AW-1:0] waddr,
                       input int fs_idx, input int fs_len, input bit junk, output int cycles);
    int pend, acks, strobes, fs_left;
    bit ended, acc, ack;
    pend = 0; acks = 0; strobes = 0; fs_left = fs_len; ended = 1'b0; cycles = 0;
    while (o_wb_cyc && !ended && cycles < 3000) begin
      cycles++;
      i_wb_stall = 1'b0;
      ack        = 1'b0;
      if (o_wb_stb) begin
        if (strobes == fs_idx && fs_left > 0) begin
          i_wb_stall = 1'b1;
          fs_left--;
        end else if ($urandom_range(99) < stall_pct) begin
          i_wb_stall = 1'b1;
        end
      end
      acc = o_wb_stb && !i_wb_stall;
      if (acks_on && (pend > 0 || (comb && acc)) && $urandom_range(99) < ack_pct) ack = 1'b1;
      i_wb_data = $urandom;
      if (abort_beat >= 0 && acks == abort_beat) begin
        ack        = 1'b0;
        i_cmd_stb  = 1'b1;
        i_cmd_word = {2'b11, DW'(0)};
        exp_rsp.push_back({2'b11, DW'(2)});
        ended = 1'b1;
      end else if (ack && acks == err_beat) begin
        i_wb_err = 1'b1;
        exp_rsp.push_back({2'b11, DW'(0)});
        ended = 1'b1;
      end else if (ack) begin
        exp_rsp.push_back(is_wr ? {2'b01, zx(waddr)} : {2'b10, i_wb_data});
        acks++;
      end else if (junk && cycles == 2) begin
        i_cmd_stb  = 1'b1;
        i_cmd_word = {2'b10, DW'($urandom)};
      end
      i_wb_ack = ack;
      if (acc) strobes++;
      pend = pend + int'(acc) - int'(ack);
      tick();
      i_wb_ack = 1'b0; i_wb_err = 1'b0; i_cmd_stb = 1'b0; i_wb_stall = 1'b0;
    end
    if (ended) begin
      chk("fail_drops_bus", {o_wb_cyc, o_wb_stb, o_cmd_busy}, 3'b000);
      exp_stb.delete();
    end else if (o_wb_cyc) begin
      n_chk++;
      $display("FAIL cycle_budget: actual=cyc still high required=cyc low");
    end else begin
      chk("busy_falls_with_cyc", o_cmd_busy, 1'b0);
    end
  endtask

  task automatic drain();
    repeat (3) tick();
    chk("rsp_queue_drained", exp_rsp.size(), 0);
    chk("stb_queue_drained", exp_stb.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int n_rsp;
    logic [AW-1:0] wa;
    i_reset = 1'b1; i_cmd_stb = 1'b0; i_cmd_word = '0;
    i_wb_err = 1'b0; i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_data = '0;
    repeat (3) tick();
    chk("reset_ctl", {o_wb_cyc, o_wb_stb, o_wb_we, o_cmd_busy, o_rsp_stb, o_wb_sel}, '0);
    chk("reset_addr", o_wb_addr, '0);
    chk("reset_wdata", o_wb_data, '0);
    chk("reset_rsp", o_rsp_word, '0);
    i_reset = 1'b0;
    tick();

    // Write with inc, then confirm post-increment address via a 1-beat read
    set_addr(10'h2AA, 1'b1);
    wr(32'hAABBCCDD, wa);
    serve(0, 100, 1'b0, -1, -1, 1'b1, 1'b1, wa, -1, 0, 1'b0, cyc);
    rd(1);
    serve(0, 100, 1'b0, -1, -1, 1'b1, 1'b0, '0, -1, 0, 1'b0, cyc);

    // Read burst, second strobe stalled for two cycles
    set_addr(10'h100, 1'b1);
    rd(4);
    serve(0, 100, 1'b0, -1, -1, 1'b1, 1'b0, '0, 1, 2, 1'b0, cyc);

    // Throughput: N beats in N+1 cycles
    set_addr(10'h040, 1'b1);
    rd(8);
    serve(0, 100, 1'b0, -1, -1, 1'b1, 1'b0, '0, -1, 0, 1'b0, cyc);
    chk("burst_cycles", cyc, 9);

    // Address wrap, then no-increment
    set_addr(10'h3FF, 1'b1);
    rd(2);
    serve(0, 100, 1'b0, -1, -1, 1'b1, 1'b0, '0, -1, 0, 1'b0, cyc);
    set_addr(10'h3FF, 1'b0);
    rd(2);
    serve(0, 100, 1'b0, -1, -1, 1'b1, 1'b0, '0, -1, 0, 1'b0, cyc);
    rd(1);
    serve(0, 100, 1'b1, -1, -1, 1'b1, 1'b0, '0, -1, 0, 1'b0, cyc);

    // Error together with the third ack
    set_addr(10'h010, 1'b1);
    rd(8);
    serve(0, 100, 1'b0, 2, -1, 1'b1, 1'b0, '0, -1, 0, 1'b0, cyc);

    // Timeout on a write, then a normal write
    set_addr(10'h020, 1'b1);
    wr(32'h12345678, wa);
    exp_rsp.push_back({2'b11, DW'(1)});
    serve(0, 100, 1'b0, -1, -1, 1'b0, 1'b1, wa, -1, 0, 1'b0, cyc);
    chk("timeout_window", (cyc >= TIMEOUT && cyc <= TIMEOUT + 1), 1'b1);
    wr(32'h0F0F0F0F, wa);
    serve(0, 100, 1'b0, -1, -1, 1'b1, 1'b1, wa, -1, 0, 1'b0, cyc);
    drain();

    // Abort mid 16-beat read; abort from idle has no effect
    set_addr(10'h000, 1'b1);
    rd(16);
    serve(20, 70, 1'b1, -1, 5, 1'b1, 1'b0, '0, -1, 0, 1'b0, cyc);
    send(2'b11, '0);
    chk("idle_abort_noop", {o_cmd_busy, o_wb_cyc}, 2'b00);
    drain();

    // Reset mid-burst: outputs clear, no response, address model back to 0
    set_addr(10'h080, 1'b1);
    rd(16);
    repeat (3) tick();
    i_reset = 1'b1;
    tick();
    chk("midreset_ctl", {o_wb_cyc, o_wb_stb, o_wb_we, o_cmd_busy, o_rsp_stb, o_wb_sel}, '0);
    chk("midreset_addr", o_wb_addr, '0);
    i_reset = 1'b0;
    exp_stb.delete();
    m_addr = '0;
    m_inc  = 1'b0;
    n_rsp  = 0;
    repeat (4) begin
      if (o_rsp_stb) n_rsp++;
      tick();
    end
    chk("no_rsp_after_reset", n_rsp, 0);
    rd(1);
    serve(0, 100, 1'b0, -1, -1, 1'b1, 1'b0, '0, -1, 0, 1'b0, cyc);

    // Random mix of commands, stalls and ack latencies
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(1) == 1) set_addr(AW'($urandom), 1'($urandom));
      if ($urandom_range(2) == 0) begin
        wr($urandom, wa);
        serve($urandom_range(40), $urandom_range(100, 40), 1'($urandom), -1, -1, 1'b1, 1'b1,
              wa, -1, 0, 1'($urandom), cyc);
      end else begin
        rd($urandom_range(16, 1));
        serve($urandom_range(40), $urandom_range(100, 40), 1'($urandom), -1, -1, 1'b1, 1'b0,
              '0, -1, 0, 1'($urandom), cyc);
      end
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wishbone_master_pipelined.md
# wishbone_master_pipelined

Parametrised successor to the single-beat Wishbone master. It decodes host command words into pipelined Wishbone B4 classic-pipelined transactions. It adds configurable data/address widths, multi-beat read bursts with outstanding-request tracking, a bus timeout, and host abort. It sits between the host command interface (debug bridge / CPU-side requester) and a Wishbone slave or interconnect.

## Interface
- DW, 32, data width; must be a multiple of 8 and at least AW+2.
- AW, 10, word address width.
- MAX_BURST, 16, maximum read beats per command; must be a power of 2. BW = $clog2(MAX_BURST).
- TIMEOUT, 255, cycles without ack before a transaction is failed. Counter width is $clog2(TIMEOUT+1).
- Clock and reset: one clock; reset is synchronous and active-high.
  - i_clk  in  1  clock; all logic on the rising edge.
  - i_reset  in  1  synchronous, active-high reset.
- Host side:
  - i_cmd_stb  in  1  command valid.
  - i_cmd_word  in  DW+2  {op[1:0], payload[DW-1:0]}.
  - o_cmd_busy  out  1  commands other than abort are ignored while high.
  - o_rsp_stb  out  1  one-cycle response pulse; no backpressure.
  - o_rsp_word  out  DW+2  {code[1:0], payload[DW-1:0]}.
- Wishbone side:
  - i_wb_err  in  1  slave error.
  - i_wb_stall  in  1  slave cannot accept a strobe this cycle.
  - i_wb_ack  in  1  slave completes one beat.
  - i_wb_data  in  DW  read data.
  - o_wb_cyc  out  1  bus cycle active.
  - o_wb_stb  out  1  request strobe.
  - o_wb_addr  out  AW  word address.
  - o_wb_we  out  1  1 = write.
  - o_wb_data  out  DW  write data.
  - o_wb_sel  out  DW/8  byte enables; all ones.

## Operation
- **Reset values:** all outputs are 0. The internal address is 0, the increment flag is 0, and the state is IDLE.
- **Command acceptance:** a command is accepted on an edge where i_cmd_stb=1 and o_cmd_busy=0. Op 11 (abort) is accepted regardless of busy.
- **Op 10, set address:** addr <= payload[AW-1:0]; inc <= payload[DW-2].
  - Response: code 00, payload = zero-extended new address.
  - Busy stays 0.
- **Op 01, write:** one beat, we=1, o_wb_data = payload, to the current address.
  - The address increments by 1 after the strobe is accepted, if inc=1.
  - On ack: response code 01, payload = the address used.
- **Op 00, read burst:** N = payload[BW-1:0]+1 beats are issued back-to-back from the current address.
  - The address advances per accepted strobe if inc=1; otherwise it is held.
  - Each ack produces response code 10 with payload = i_wb_data.
- **Op 11, abort:**
  - From IDLE: no effect and no response.
  - Otherwise: o_wb_cyc and o_wb_stb drop on the next edge, remaining beats are discarded, and the block returns to IDLE. Response: code 11, payload 2.
- **State machine:** IDLE -> WRITE / READ on command acceptance; WRITE / READ -> IDLE on the last ack, error, timeout or abort.
- **Outstanding tracking:**
  - issued counts strobes with stall=0; acked counts acks.
  - o_wb_stb drops when issued = N.
  - o_wb_cyc drops on the edge where acked reaches N.
  - Acks arriving while acked = issued are ignored.
- **Error:** i_wb_err while cyc=1 drops cyc and stb on the next edge. Response: code 11, payload 0. Remaining beats are discarded. Err wins over a simultaneous ack.
- **Timeout:**
  - The counter runs while cyc=1 and clears on every ack.
  - When it reaches TIMEOUT: cyc drops, response code 11, payload 1.
- **Address arithmetic:** the address is AW bits and wraps modulo 2^AW (e.g. 0x3FF -> 0x000).

## Timing
- **Command to bus:** command accepted at edge k → cyc, stb and busy are all 1 after edge k.
- **Stall:** o_wb_stb, o_wb_addr, o_wb_we and o_wb_data are held stable while i_wb_stall=1.
- **Combinational slave:** an ack in the same cycle as an accepted stb is legal and is counted.
- **Ack to response:** ack at edge j → o_rsp_stb=1 for exactly the cycle after edge j.
- **Burst throughput:** with no stall and single-cycle acks, N beats complete in N+1 cycles from the first stb.
- **Release after completion:** busy falls on the same edge cyc falls; a new command can be accepted on the following edge.
- **Address response latency:** the set-address response is 1 cycle after acceptance.
- **Reset mid-transaction:** cyc and stb are 0 after the reset edge, no response is emitted, and all counters clear.

## Test plan
- **Write:** set address 0x2AA with inc=1, then write 0xAABBCCDD, slave acks one cycle later.
  - o_wb_addr = 0x2AA, we=1.
  - Response {01, 0x2AA}.
  - Internal address 0x2AB.
- **Read burst with stall:** set address 0x100 with inc=1, read with payload 3, slave stalls the 2nd strobe for 2 cycles and returns data 0x11, 0x22, 0x33, 0x44.
  - Four code-10 responses in order.
  - Addresses 0x100–0x103 issued.
  - cyc drops after the 4th ack.
- **Address wrap and no-increment:** set address 0x3FF with inc=1 and read 2 beats → addresses 0x3FF, 0x000. Repeat with inc=0 → addresses 0x3FF, 0x3FF.
- **Error mid-burst:** 8-beat read, i_wb_err asserted together with the 3rd ack.
  - 2 data responses, then {11, 0}.
  - cyc=0 the next cycle.
  - busy clears.
- **Timeout:** write with the slave never acking.
  - After TIMEOUT cycles: response {11, 1} and cyc=0.
  - A following write that is acked completes normally.
- **Abort and reset:** abort during a 16-beat read → response {11, 2} and cyc=0 the next cycle. Reset asserted mid-burst → all outputs 0 and no response.
